// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode types, widths and opcode constants
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // Redirect targets from execute may carry junk in the low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// rtl/fetch_out_reg.sv - one-entry valid/ready output buffer with flush
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop the buffered entry (wins over load and drain)
//   load, load_data     write a new entry (only issued while empty)
//   out_valid/out_ready downstream handshake, out_data buffered entry
module fetch_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      // A flush beats a same-cycle consume: the entry is discarded, not delivered.
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request/response, decode output
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr instruction memory request channel
//   imem_rsp_valid, imem_rsp_data   one response per accepted request
//   redirect_valid, redirect_pc     PC override from execute
//   instr_valid/ready, instr,
//   instr_pc                        registered output to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic            squash, squash_n;
  logic            rsp_load;
  logic            req_fire;

  // Requests wait for an empty output register so only one fetch is ever in flight.
  assign imem_req_valid = (state == REQ) && !instr_valid;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      squash   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fetch_pc <= fetch_pc_n;
      squash   <= squash_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fetch_pc_n = fetch_pc;
    squash_n   = squash;
    rsp_load   = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (req_fire) begin
          fetch_pc_n = pc;
          pc_n       = pc + XLEN'(INSTR_BYTES);
          state_n    = WAIT;
          // The request already left with the old PC; its response must be dropped.
          if (redirect_valid) squash_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_n  = REQ;
          squash_n = 1'b0;
          rsp_load = !squash && !redirect_valid;
        end else if (redirect_valid) begin
          squash_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Redirect target overrides the sequential increment.
    if (redirect_valid) pc_n = align_pc(redirect_pc);
  end

  fetch_out_reg #(
    .W(2 * XLEN)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .load      (rsp_load),
    .load_data ({imem_rsp_data, fetch_pc}),
    .out_valid (instr_valid),
    .out_ready (instr_ready),
    .out_data  ({instr, instr_pc})
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  // Reference model: next sequential PC, the single outstanding fetch, the buffered output.
  logic [31:0] m_pc;
  bit          m_idle;
  bit          out_busy, out_live;
  int          out_cnt;
  logic [31:0] out_addr;
  bit          m_buf_v;
  logic [31:0] m_buf_i, m_buf_pc;
  int          lat = 1;
  bit          force_rsp = 1'b0;
  logic [31:0] hs_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks outputs, advances model.
  task automatic step(input bit rr, input bit rd, input logic [31:0] rt, input bit dr);
    bit rsp, exp_req, hs;
    rsp = (out_busy && out_cnt == 1) || force_rsp;
    imem_req_ready = rr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = (out_busy && out_cnt == 1) ? memf(out_addr) : $urandom;
    redirect_valid = rd;
    redirect_pc    = rt;
    instr_ready    = dr;

    exp_req = !m_idle && !out_busy && !m_buf_v;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_buf_v});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    if (m_buf_v) begin
      chk("instr", instr, m_buf_i);
      chk("instr_pc", instr_pc, m_buf_pc);
    end

    hs = exp_req && rr;
    if (m_buf_v && dr && !rd) begin
      m_buf_v = 1'b0;
      n_out++;
    end
    if (rsp && out_busy) begin
      out_busy = 1'b0;
      if (out_live) begin
        m_buf_v  = 1'b1;
        m_buf_i  = memf(out_addr);
        m_buf_pc = out_addr;
      end
    end else if (out_busy) begin
      out_cnt--;
    end
    if (hs) begin
      hs_log.push_back(m_pc);
      out_busy = 1'b1;
      out_live = 1'b1;
      out_cnt  = lat;
      out_addr = m_pc;
      m_pc     = m_pc + 32'd4;
    end
    if (rd) begin
      m_pc     = {rt[31:2], 2'b00};
      m_buf_v  = 1'b0;
      out_live = 1'b0;
    end
    m_idle = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC; m_idle = 1'b1;
    out_busy = 1'b0; out_live = 1'b0; m_buf_v = 1'b0;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req_valid && k < 30) begin step(1'b0, 1'b0, 32'd0, 1'b1); k++; end
    chk("wait_req_timeout", {31'b0, imem_req_valid}, 32'd1);
  endtask

  task automatic wait_ivalid();
    int k = 0;
    while (!instr_valid && k < 30) begin step(1'b1, 1'b0, 32'd0, 1'b0); k++; end
    chk("wait_ivalid_timeout", {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] s_i, s_pc;
    int hs0;
    rst = 1'b1;
    do_reset();

    // Straight-line fetch from RESET_PC with a 1-cycle memory.
    repeat (12) step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("seq_addr0", hs_log[0], 32'h100);
    chk("seq_addr1", hs_log[1], 32'h104);
    chk("seq_addr2", hs_log[2], 32'h108);
    chk("seq_outputs", {31'b0, n_out >= 3}, 32'd1);

    // Decode stall: output stable and no new request.
    wait_ivalid();
    s_i = instr; s_pc = instr_pc;
    repeat (5) begin
      chk("stall_instr", instr, s_i);
      chk("stall_pc", instr_pc, s_pc);
      chk("stall_req", {31'b0, imem_req_valid}, 32'd0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    wait_req();
    chk("after_stall_addr", imem_addr, s_pc + 32'd4);

    // Redirect while waiting on a slow response: response dropped.
    lat = 3;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h2002, 1'b1);
    wait_req();
    chk("redir_wait_addr", imem_addr, 32'h2000);

    // Redirect in the same cycle as the request handshake.
    lat = 1;
    step(1'b1, 1'b1, 32'h3000, 1'b1);
    wait_req();
    chk("redir_hs_addr", imem_addr, 32'h3000);

    // Redirect in the same cycle decode consumes a buffered instruction.
    wait_ivalid();
    hs0 = n_out;
    step(1'b1, 1'b1, 32'h4000, 1'b1);
    chk("redir_buf_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_buf_no_credit", n_out, hs0);

    // PC wrap at the top of the address space.
    wait_req();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    wait_req();
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    wait_req();
    chk("wrap_zero", imem_addr, 32'h0000_0000);

    // Reset while a response is outstanding; the late response lands in IDLE.
    lat = 3;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    do_reset();
    force_rsp = 1'b1;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    force_rsp = 1'b0;
    chk("post_rst_addr", imem_addr, RST_PC);
    repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rt;
      lat = $urandom_range(1, 4);
      rt  = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      if ($urandom % 600 == 0) do_reset();
      else step($urandom % 4 != 0, $urandom % 16 == 0, rt, $urandom % 3 != 0);
    end
    chk("random_outputs", {31'b0, n_out > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
